// File: rtl/b128to32_ser_pkg.sv
// Shared widths and the word-select helper for the 128/32 serializer and its gatherer.
// Word 0 is the most significant word of a block.
package b128to32_ser_pkg;

  localparam int WORD_W  = 32;
  localparam int NWORDS  = 4;
  localparam int IDX_W   = $clog2(NWORDS);
  localparam int BLOCK_W = WORD_W * NWORDS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  function automatic logic [WORD_W-1:0] word(input logic [BLOCK_W-1:0] blk,
                                             input logic [IDX_W-1:0]   k);
    return blk[BLOCK_W - 1 - WORD_W * int'(k) -: WORD_W];
  endfunction

endpackage

// File: rtl/b128_hold_buf.sv
// Single-entry holding register for one pending block.
// A push always wins over a pop. The core never asks for both in one cycle.
module b128_hold_buf
  import b128to32_ser_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [BLOCK_W-1:0] i_data,
  output logic               o_valid,
  output logic [BLOCK_W-1:0] o_data
);

  logic               r_valid;
  logic [BLOCK_W-1:0] r_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/b128to32_ser.sv
// Serializes each 128-bit block into four 32-bit words, most significant word first.
// A one-block holding buffer lets blocks stream back to back with no bubble.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// A producer holding valid must keep its data steady until that edge.
// in_ready is computed from registers only. The out_* signals are registered and do
// not depend on in_* in the same cycle.
module b128to32_ser
  import b128to32_ser_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] dataIn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  dataOut,
  output logic [IDX_W-1:0]   nr,
  output logic               last
);

  logic [BLOCK_W-1:0] r_active;
  logic               r_act_valid;
  logic [IDX_W-1:0]   r_cnt;
  logic [WORD_W-1:0]  r_data_out;

  logic               w_hold_valid;
  logic [BLOCK_W-1:0] w_hold_data;
  logic               w_hold_push;
  logic               w_hold_pop;

  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_drain;

  logic [BLOCK_W-1:0] w_next_active;
  logic               w_next_act_valid;
  logic [IDX_W-1:0]   w_next_cnt;

  assign in_ready   = !w_hold_valid && !reset;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_act_valid && out_ready;
  assign w_drain    = w_out_fire && (r_cnt == LAST_IDX);

  always_comb begin
    w_next_active    = r_active;
    w_next_act_valid = r_act_valid;
    w_next_cnt       = r_cnt;
    w_hold_push      = 1'b0;
    w_hold_pop       = 1'b0;

    if (!r_act_valid) begin
      if (w_in_fire) begin
        w_next_active    = dataIn;
        w_next_act_valid = 1'b1;
        w_next_cnt       = '0;
      end
    end else if (w_drain) begin
      w_next_cnt = '0;
      if (w_hold_valid) begin
        w_next_active = w_hold_data;
        w_hold_pop    = 1'b1;
      end else if (w_in_fire) begin
        w_next_active = dataIn;
      end else begin
        w_next_act_valid = 1'b0;
      end
    end else begin
      if (w_out_fire) begin
        w_next_cnt = r_cnt + IDX_W'(1);
      end
      // A block that arrives mid-drain waits in hold. The active block is not disturbed.
      if (w_in_fire) begin
        w_hold_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_active    <= '0;
      r_act_valid <= 1'b0;
      r_cnt       <= '0;
      r_data_out  <= '0;
    end else begin
      r_active    <= w_next_active;
      r_act_valid <= w_next_act_valid;
      r_cnt       <= w_next_cnt;
      // The output word is registered, so it keeps its last value once the core goes idle.
      if (w_next_act_valid) begin
        r_data_out <= word(w_next_active, w_next_cnt);
      end
    end
  end

  b128_hold_buf u_hold (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_hold_push),
    .i_pop   (w_hold_pop),
    .i_data  (dataIn),
    .o_valid (w_hold_valid),
    .o_data  (w_hold_data)
  );

  assign out_valid = r_act_valid;
  assign dataOut   = r_data_out;
  assign nr        = r_cnt;
  assign last      = r_act_valid && (r_cnt == LAST_IDX);

endmodule

// File: tb/tb_b128to32_ser.sv
// Directed bench for b128to32_ser: reset, single block, streaming, stalls, loopback, mid-block reset, fill.
module tb_b128to32_ser;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dataIn;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  dataOut;
  logic [1:0]   nr;
  logic         last;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  b128to32_ser dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataIn    (dataIn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataOut   (dataOut),
    .nr        (nr),
    .last      (last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] b, input int k);
    return b[127 - 32 * k -: 32];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL reset_dataOut: got %h want 0", dataOut); end
    total++; if (nr !== 2'd0) begin bad++; $display("FAIL reset_nr: got %0d want 0", nr); end
    total++; if (last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", last); end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    logic [31:0] w[4];
    w[0] = 32'h00112233; w[1] = 32'h44556677; w[2] = 32'h8899AABB; w[3] = 32'hCCDDEEFF;
    in_valid  = 1'b1;
    dataIn    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d]: got %b want 1", k, out_valid); end
      total++; if (dataOut !== w[k]) begin bad++; $display("FAIL single_data[%0d]: got %h want %h", k, dataOut, w[k]); end
      total++; if (nr !== 2'(k)) begin bad++; $display("FAIL single_nr[%0d]: got %0d want %0d", k, nr, k); end
      total++; if (last !== (k == 3)) begin bad++; $display("FAIL single_last[%0d]: got %b want %b", k, last, (k == 3)); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blks[3];
    logic         exp_rdy[12];
    logic         f_in;
    int           bi;
    blks[0] = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    blks[1] = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    blks[2] = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_q.delete();
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 4; k++) exp_q.push_back(wsel(blks[b], k));
    bi        = 0;
    in_valid  = 1'b1;
    dataIn    = blks[0];
    out_ready = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      f_in = in_valid && in_ready;
      step();
      if (f_in) begin
        bi++;
        if (bi < 3) dataIn = blks[bi];
        else in_valid = 1'b0;
      end
      if (c <= 12) begin
        logic [31:0] ew;
        ew = exp_q.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_gap[%0d]: got out_valid=%b want 1", c, out_valid); end
        total++; if (dataOut !== ew) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", c, dataOut, ew); end
        total++; if (nr !== 2'((c - 1) % 4)) begin bad++; $display("FAIL b2b_nr[%0d]: got %0d want %0d", c, nr, (c - 1) % 4); end
        total++; if (in_ready !== exp_rdy[c-1]) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy[c-1]); end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] blk_d, blk_e;
    logic         f_in, f_out, stalled;
    logic [31:0]  sd;
    logic [1:0]   sn;
    logic         sl;
    int           p, k, nsent;
    blk_d = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    blk_e = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    exp_q.delete();
    for (int j = 0; j < 4; j++) exp_q.push_back(wsel(blk_d, j));
    for (int j = 0; j < 4; j++) exp_q.push_back(wsel(blk_e, j));
    in_valid = 1'b1;
    dataIn   = blk_d;
    nsent    = 0;
    p        = 0;
    k        = 0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      out_ready = (p % 3 == 0);
      p++;
      if (out_valid) begin
        total++; if (dataOut !== exp_q[0]) begin bad++; $display("FAIL stall_data: got %h want %h", dataOut, exp_q[0]); end
        total++; if (nr !== 2'(k)) begin bad++; $display("FAIL stall_nr: got %0d want %0d", nr, k); end
        total++; if (last !== (k == 3)) begin bad++; $display("FAIL stall_last: got %b want %b", last, (k == 3)); end
      end
      f_in    = in_valid && in_ready;
      f_out   = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      sd = dataOut; sn = nr; sl = last;
      step();
      if (f_in) begin
        nsent++;
        if (nsent == 1) dataIn = blk_e;
        else in_valid = 1'b0;
      end
      if (f_out) begin
        void'(exp_q.pop_front());
        k = (k + 1) % 4;
      end
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || dataOut !== sd || nr !== sn || last !== sl) begin
          bad++; $display("FAIL stall_hold: got v=%b %h nr=%0d l=%b want v=1 %h nr=%0d l=%b", out_valid, dataOut, nr, last, sd, sn, sl);
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_timeout: got %0d words left want 0", exp_q.size()); end
    out_ready = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_loopback();
    logic [127:0] blk_q[$];
    logic [127:0] gath, eb;
    logic [31:0]  d;
    logic [1:0]   n;
    logic         l, f_in, f_out;
    int           sent, rcv, cyc;
    sent = 0; rcv = 0; cyc = 0;
    gath = '0;
    in_valid = 1'b0;
    while ((sent < 100 || rcv < 100) && cyc < 5000) begin
      cyc++;
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        dataIn   = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      f_in  = in_valid && in_ready;
      f_out = out_valid && out_ready;
      d = dataOut; n = nr; l = last;
      step();
      if (f_in) begin
        blk_q.push_back(dataIn);
        sent++;
        in_valid = 1'b0;
      end
      if (f_out) begin
        gath[127 - 32 * int'(n) -: 32] = d;
        if (l) begin
          rcv++;
          total++;
          if (blk_q.size() == 0) begin
            bad++; $display("FAIL loop_extra: got block %h want none", gath);
          end else begin
            eb = blk_q.pop_front();
            if (gath !== eb) begin bad++; $display("FAIL loop_block[%0d]: got %h want %h", rcv, gath, eb); end
          end
        end
      end
    end
    total++; if (rcv != 100) begin bad++; $display("FAIL loop_timeout: got %0d blocks want 100", rcv); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] blk_f, blk_g, blk_h;
    blk_f = 128'h11110000_11110001_11110002_11110003;
    blk_g = 128'h22220000_22220001_22220002_22220003;
    blk_h = 128'h33330000_33330001_33330002_33330003;
    in_valid  = 1'b1;
    dataIn    = blk_f;
    out_ready = 1'b0;
    step();
    dataIn    = blk_g;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++; if (nr !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL rmid_setup: got nr=%0d in_ready=%b want nr=2 in_ready=0", nr, in_ready); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    total++; if (nr !== 2'd0) begin bad++; $display("FAIL rmid_nr: got %0d want 0", nr); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    dataIn   = blk_h;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || dataOut !== wsel(blk_h, k) || nr !== 2'(k)) begin
        bad++; $display("FAIL rmid_word[%0d]: got v=%b %h nr=%0d want v=1 %h nr=%0d", k, out_valid, dataOut, nr, wsel(blk_h, k), k);
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale: got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    logic [127:0] blk_j, blk_k;
    logic         f_in;
    int           acc;
    blk_j = 128'h4444AAAA_4444BBBB_4444CCCC_4444DDDD;
    blk_k = 128'h5555AAAA_5555BBBB_5555CCCC_5555DDDD;
    in_valid  = 1'b1;
    dataIn    = blk_j;
    out_ready = 1'b0;
    acc       = 0;
    for (int c = 0; c < 10; c++) begin
      f_in = in_valid && in_ready;
      step();
      if (f_in) begin
        acc++;
        dataIn = blk_k;
      end
      total++;
      if (out_valid !== 1'b1 || nr !== 2'd0 || dataOut !== 32'h4444AAAA) begin
        bad++; $display("FAIL fill_stall[%0d]: got v=%b nr=%0d %h want v=1 nr=0 4444aaaa", c, out_valid, nr, dataOut);
      end
    end
    total++; if (acc != 2) begin bad++; $display("FAIL fill_accepts: got %0d want 2", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic [31:0] ew;
      ew = (c < 4) ? wsel(blk_j, c) : wsel(blk_k, c - 4);
      total++;
      if (out_valid !== 1'b1 || dataOut !== ew) begin
        bad++; $display("FAIL fill_drain[%0d]: got v=%b %h want v=1 %h", c, out_valid, dataOut, ew);
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_idle: got %b want 0", out_valid); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    dataIn    = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_loopback();
    test_reset_mid();
    test_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
